// File: rtl/fp16_pkg.sv
// Shared FP16 (1/5/10) field widths, special-value constants and the divider state encoding.
package fp16_pkg;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned BIAS  = 15;

    typedef logic [EXP_W-1:0] exp_t;
    typedef logic [MAN_W-1:0] man_t;

    localparam exp_t EXP_MAX  = 5'd31;
    localparam man_t QNAN_MAN = 10'h200;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

endpackage

// File: rtl/fp16_divider_if.sv
// Operand/result handshake bundle for the FP16 divider; master drives operands, slave is the divider.
interface fp16_divider_if;
    import fp16_pkg::*;

    logic in_valid;
    logic in_ready;
    logic in_a_sign;
    exp_t in_a_exponent;
    man_t in_a_mantissa;
    logic in_b_sign;
    exp_t in_b_exponent;
    man_t in_b_mantissa;

    logic out_valid;
    logic out_ready;
    logic out_sign;
    exp_t out_exponent;
    man_t out_mantissa;
    logic out_dbz;

    modport master (
        output in_valid, in_a_sign, in_a_exponent, in_a_mantissa,
        output in_b_sign, in_b_exponent, in_b_mantissa, out_ready,
        input  in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_dbz
    );

    modport slave (
        input  in_valid, in_a_sign, in_a_exponent, in_a_mantissa,
        input  in_b_sign, in_b_exponent, in_b_mantissa, out_ready,
        output in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_dbz
    );

endinterface

// File: rtl/fp16_div_special.sv
// Combinational operand classifier: flags pairs that bypass the iterative path and forms their result.
module fp16_div_special
    import fp16_pkg::*;
(
    input  logic a_sign_i,
    input  exp_t a_exp_i,
    input  man_t a_man_i,
    input  logic b_sign_i,
    input  exp_t b_exp_i,
    input  man_t b_man_i,
    output logic is_special_o,
    output logic sign_o,
    output exp_t exp_o,
    output man_t man_o,
    output logic dbz_o
);

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    always_comb begin
        // Zero exponent means zero regardless of mantissa (denormals treated as zero).
        a_zero = (a_exp_i == '0);
        a_inf  = (a_exp_i == EXP_MAX) && (a_man_i == '0);
        a_nan  = (a_exp_i == EXP_MAX) && (a_man_i != '0);
        b_zero = (b_exp_i == '0);
        b_inf  = (b_exp_i == EXP_MAX) && (b_man_i == '0);
        b_nan  = (b_exp_i == EXP_MAX) && (b_man_i != '0);

        is_special_o = 1'b1;
        sign_o       = a_sign_i ^ b_sign_i;
        exp_o        = EXP_MAX;
        man_o        = '0;
        dbz_o        = 1'b0;

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sign_o = 1'b0;
            man_o  = QNAN_MAN;
        end else if (b_zero) begin
            dbz_o = 1'b1;
        end else if (!a_inf) begin
            // Remaining specials are finite/inf and 0/x, both signed zero.
            exp_o        = '0;
            is_special_o = b_inf || a_zero;
        end
    end

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider: restoring radix-2 mantissa division, one quotient bit per cycle.
module fp16_divider #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned BIAS  = 15
) (
    input  logic           clock,
    input  logic           reset,
    fp16_divider_if.slave  io
);
    import fp16_pkg::*;

    if (EXP_W != 5 || MAN_W != 10) begin : g_bad_width
        $error("fp16_divider supports only EXP_W=5 and MAN_W=10");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] rem_q, rem_d, rem_sub;
    logic [10:0] mb_q, mb_d;
    logic [11:0] quo_q, quo_d;
    logic [6:0]  exp_q, exp_d, e_norm;
    logic        sign_q, sign_d;
    logic        dbz_q, dbz_d;
    exp_t        oexp_q, oexp_d;
    man_t        oman_q, oman_d, man_norm;

    logic sp_is_special, sp_sign, sp_dbz;
    exp_t sp_exp;
    man_t sp_man;

    fp16_div_special u_special (
        .a_sign_i     (io.in_a_sign),
        .a_exp_i      (io.in_a_exponent),
        .a_man_i      (io.in_a_mantissa),
        .b_sign_i     (io.in_b_sign),
        .b_exp_i      (io.in_b_exponent),
        .b_man_i      (io.in_b_mantissa),
        .is_special_o (sp_is_special),
        .sign_o       (sp_sign),
        .exp_o        (sp_exp),
        .man_o        (sp_man),
        .dbz_o        (sp_dbz)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        dbz_d    = dbz_q;
        oexp_d   = oexp_q;
        oman_d   = oman_q;
        rem_sub  = rem_q - {1'b0, mb_q};
        // exp_q holds ea-eb+BIAS-1; a leading quotient one adds the missing unit back.
        e_norm   = exp_q + {6'd0, quo_q[11]};
        man_norm = quo_q[11] ? quo_q[10:1] : quo_q[9:0];

        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    if (sp_is_special) begin
                        state_d = DONE;
                        sign_d  = sp_sign;
                        oexp_d  = sp_exp;
                        oman_d  = sp_man;
                        dbz_d   = sp_dbz;
                    end else begin
                        state_d = DIV;
                        cnt_d   = '0;
                        rem_d   = {2'b01, io.in_a_mantissa};
                        mb_d    = {1'b1, io.in_b_mantissa};
                        quo_d   = '0;
                        exp_d   = {2'b00, io.in_a_exponent} - {2'b00, io.in_b_exponent}
                                  + 7'(BIAS - 1);
                        sign_d  = io.in_a_sign ^ io.in_b_sign;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DIV: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    rem_d = rem_sub << 1;
                    quo_d = {quo_q[10:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    quo_d = {quo_q[10:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                if ($signed(e_norm) >= 7'sd31) begin
                    oexp_d = EXP_MAX;
                    oman_d = '0;
                end else if ($signed(e_norm) <= 7'sd0) begin
                    oexp_d = '0;
                    oman_d = '0;
                end else begin
                    oexp_d = e_norm[4:0];
                    oman_d = man_norm;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            dbz_q   <= 1'b0;
            oexp_q  <= '0;
            oman_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            dbz_q   <= dbz_d;
            oexp_q  <= oexp_d;
            oman_q  <= oman_d;
        end
    end

    assign io.in_ready     = (state_q == IDLE);
    assign io.out_valid    = (state_q == DONE);
    assign io.out_sign     = sign_q;
    assign io.out_exponent = oexp_q;
    assign io.out_mantissa = oman_q;
    assign io.out_dbz      = dbz_q;

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider: directed cases plus randomized pairs against a value-level model.
module tb_fp16_divider;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fp16_divider_if io ();

    fp16_divider dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] result();
        return {io.out_sign, io.out_exponent, io.out_mantissa};
    endfunction

    // Reference: {special, dbz, q}. Quotient is the truncated real ratio of the 11-bit significands.
    function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int  ea, eb, ma, mb, e, man;
        logic s, az, ai, an, bz, bi, bn;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        az = (ea == 0);
        ai = (ea == 31) && (a[9:0] == 0);
        an = (ea == 31) && (a[9:0] != 0);
        bz = (eb == 0);
        bi = (eb == 31) && (b[9:0] == 0);
        bn = (eb == 31) && (b[9:0] != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {2'b10, 16'h7E00};
        if (bz) return {2'b11, s, 5'd31, 10'd0};
        if (ai) return {2'b10, s, 5'd31, 10'd0};
        if (bi || az) return {2'b10, s, 15'd0};
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        if (ma >= mb) begin
            e   = ea - eb + 15;
            man = (ma * 1024) / mb - 1024;
        end else begin
            e   = ea - eb + 14;
            man = (ma * 2048) / mb - 1024;
        end
        if (e >= 31) return {2'b00, s, 5'd31, 10'd0};
        if (e <= 0) return {2'b00, s, 15'd0};
        return {2'b00, s, 5'(e), 10'(man)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:10] = 5'd0;
            1: v[14:10] = 5'd31;
            2: v[14:0] = 15'h7C00;
            3, 4, 5: v[14:10] = 5'($urandom_range(8, 22));
            default: ;
        endcase
        return v;
    endfunction

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
        io.in_a_sign     = a[15];
        io.in_a_exponent = a[14:10];
        io.in_a_mantissa = a[9:0];
        io.in_b_sign     = b[15];
        io.in_b_exponent = b[14:10];
        io.in_b_mantissa = b[9:0];
    endtask

    // Called and returns at a falling edge. Latency counts edges from the accept edge inclusive.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int stall, input logic [16:0] want, input int want_lat);
        int guard;
        int lat;
        guard = 0;
        while (!io.in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
        set_ops(a, b);
        io.in_valid = 1'b1;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        io.in_valid = 1'b0;
        while (!io.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(want_lat));
        check({tag, "_result"}, 32'(result()), 32'(want[15:0]));
        check({tag, "_dbz"}, 32'(io.out_dbz), 32'(want[16]));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check({tag, "_hold"}, 32'({io.out_dbz, result()}), 32'(want));
            check({tag, "_hold_rdy_vld"}, 32'({io.in_ready, io.out_valid}), 32'b01);
        end
        io.out_ready = 1'b1;
        check({tag, "_no_overlap"}, 32'(io.in_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        io.out_ready = 1'b0;
        check({tag, "_consumed"}, 32'({io.in_ready, io.out_valid}), 32'b10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, b;
        logic [17:0] r;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        set_ops(16'h0, 16'h0);

        #12;
        check("reset_rdy_vld", 32'({io.in_ready, io.out_valid}), 32'b10);
        check("reset_outputs", 32'({io.out_dbz, result()}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("div_6_2", 16'h4600, 16'h4000, 0, {1'b0, 16'h4200}, 14);
        run_op("div_1_3", 16'h3C00, 16'h4200, 0, {1'b0, 16'h3555}, 14);
        run_op("div_m1_3", 16'hBC00, 16'h4200, 1, {1'b0, 16'hB555}, 14);
        run_op("overflow", 16'h7BFF, 16'h3800, 0, {1'b0, 16'h7C00}, 14);
        run_op("underflow", 16'h0400, 16'h4000, 0, {1'b0, 16'h0000}, 14);
        run_op("x_div_0", 16'h3C00, 16'h0000, 0, {1'b1, 16'h7C00}, 1);
        run_op("0_div_0", 16'h0000, 16'h0000, 0, {1'b0, 16'h7E00}, 1);
        run_op("inf_inf", 16'h7C00, 16'h7C00, 0, {1'b0, 16'h7E00}, 1);
        run_op("x_div_ninf", 16'h3C00, 16'hFC00, 0, {1'b0, 16'h8000}, 1);
        run_op("backpressure", 16'h4600, 16'h4000, 5, {1'b0, 16'h4200}, 14);

        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            r = ref_div(a, b);
            run_op($sformatf("rnd%0d_%04h_%04h", i, a, b), a, b, int'($urandom_range(0, 2)),
                   r[16:0], r[17] ? 1 : 14);
        end

        // Reset in the middle of the iterative phase (iteration 6).
        run_op("pre_reset", 16'hC700, 16'h3E00, 0, ref_div(16'hC700, 16'h3E00) >> 0, 14);
        set_ops(16'h4600, 16'h4000);
        io.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        io.in_valid = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_reset_rdy_vld", 32'({io.in_ready, io.out_valid}), 32'b10);
        check("mid_reset_outputs", 32'({io.out_dbz, result()}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("after_reset", 16'h4600, 16'h4000, 0, {1'b0, 16'h4200}, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
